// File: rtl/cpu_6502_bus_resp.sv
// rtl/cpu_6502_bus_resp.sv - memory-side bus responder for the cpu_6502 core
//
// Serves AB < 2^RAM_AW from on-chip RAM with zero wait states; forwards every
// other address to a slow external port over a level req / pulse ack handshake,
// holding RDY low until ack or timeout.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   AB/DO/WE   CPU address, write data, write enable
//   DI         registered read data to the CPU
//   RDY        registered CPU ready (0 stalls the CPU)
//   ext_req    external request level
//   ext_we     external write flag (valid with ext_req)
//   ext_addr   latched external address
//   ext_wdata  latched external write data
//   ext_rdata  external read data, valid with ext_ack
//   ext_ack    one-cycle external completion pulse
//   bus_err    sticky timeout flag
//   err_clr    clears bus_err
//
// TIMEOUT must lie in 1..255 (8-bit wait counter).

module cpu_6502_bus_resp #(
  parameter int RAM_AW  = 11,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err,
  input  logic        err_clr
);

  typedef enum logic {IDLE, EXT_WAIT} state_t;

  localparam int         RAM_DEPTH = 1 << RAM_AW;
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  logic [7:0] ram [RAM_DEPTH];

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [RAM_AW-1:0] ram_addr;
  logic              int_hit;
  logic              ack_done;
  logic              tmo_hit;

  logic [7:0]  di_nxt;
  logic        rdy_nxt;
  logic        req_nxt;
  logic        we_nxt;
  logic [15:0] addr_nxt;
  logic [7:0]  wdata_nxt;
  logic        err_nxt;
  logic        ram_we;

  assign ram_addr = AB[RAM_AW-1:0];
  assign int_hit  = (AB >> RAM_AW) == 16'd0;

  // Ack has priority over the timeout on the same edge.
  assign ack_done = (state == EXT_WAIT) && ext_ack;
  assign tmo_hit  = (state == EXT_WAIT) && !ext_ack && (cnt == TMO_LAST);

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      DI        <= 8'h00;
      RDY       <= 1'b1;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 16'h0000;
      ext_wdata <= 8'h00;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      DI        <= di_nxt;
      RDY       <= rdy_nxt;
      ext_req   <= req_nxt;
      ext_we    <= we_nxt;
      ext_addr  <= addr_nxt;
      ext_wdata <= wdata_nxt;
      bus_err   <= err_nxt;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= DO;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (!int_hit) begin
          state_nxt = EXT_WAIT;
          cnt_nxt   = 8'd0;
        end
      end
      EXT_WAIT: begin
        if (ack_done || tmo_hit) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    di_nxt    = DI;
    rdy_nxt   = RDY;
    req_nxt   = ext_req;
    we_nxt    = ext_we;
    addr_nxt  = ext_addr;
    wdata_nxt = ext_wdata;
    err_nxt   = bus_err;
    ram_we    = 1'b0;

    // Timeout set beats a simultaneous clear
    if (tmo_hit) begin
      err_nxt = 1'b1;
    end else if (err_clr) begin
      err_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (int_hit) begin
          rdy_nxt = 1'b1;
          if (WE) begin
            ram_we = 1'b1;
          end else begin
            di_nxt = ram[ram_addr];
          end
        end else begin
          addr_nxt  = AB;
          we_nxt    = WE;
          wdata_nxt = DO;
          req_nxt   = 1'b1;
          rdy_nxt   = 1'b0;
        end
      end
      EXT_WAIT: begin
        if (ack_done) begin
          req_nxt = 1'b0;
          rdy_nxt = 1'b1;
          if (!ext_we) begin
            di_nxt = ext_rdata;
          end
        end else if (tmo_hit) begin
          req_nxt = 1'b0;
          rdy_nxt = 1'b1;
          if (!ext_we) begin
            di_nxt = 8'hFF;
          end
        end
      end
      default: begin
        req_nxt = 1'b0;
        rdy_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_6502_bus_resp.sv
// tb/tb_cpu_6502_bus_resp.sv - self-checking bench for cpu_6502_bus_resp

module tb_cpu_6502_bus_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        RDY;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic        bus_err;
  logic        err_clr;

  int n_cmp = 0;
  int n_err = 0;

  cpu_6502_bus_resp #(.RAM_AW(11), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .AB        (AB),
    .DO        (DO),
    .WE        (WE),
    .DI        (DI),
    .RDY       (RDY),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .bus_err   (bus_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ab;
    logic [7:0]  dout;
    logic        we;
    logic        ack;
    logic [7:0]  rdata;
    logic        clr;
    logic [7:0]  e_di;
    logic        e_rdy;
    logic        e_req;
    logic        e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] ab, input logic [7:0] dout, input logic we,
                     input logic ack, input logic [7:0] rdata,
                     input logic [7:0] e_di, input logic e_rdy, input logic e_req,
                     input logic e_we, input logic [15:0] e_addr, input logic [7:0] e_wdata);
    vq.push_back('{ab, dout, we, ack, rdata, 1'b0, e_di, e_rdy, e_req, e_we, e_addr, e_wdata, 1'b0});
  endtask

  // Starts an external access and runs the wait phase; ack_edge=0 means no ack.
  task automatic run_ext(input logic [15:0] ab, input logic [7:0] dout, input logic we,
                         input int ack_edge, input logic [7:0] rdata, input logic clr,
                         output int stall);
    int w;
    AB = ab; DO = dout; WE = we; ext_ack = 1'b0; err_clr = clr;
    step();
    stall = RDY ? 0 : 1;
    w = 0;
    while (!RDY && w < 40) begin
      w++;
      ext_ack   = (w == ack_edge);
      ext_rdata = rdata;
      step();
      ext_ack = 1'b0;
      if (!RDY) stall++;
    end
    if (w >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_bound: RDY still %b after %0d edges, required 1", RDY, w);
    end
    err_clr = 1'b0;
  endtask

  initial begin
    int stall;

    reset = 1'b0; AB = 16'h0000; DO = 8'h00; WE = 1'b0;
    ext_rdata = 8'h00; ext_ack = 1'b0; err_clr = 1'b0;

    //   ab       do     we    ack   rdata  e_di   rdy   req   we    addr      wdata
    add(16'h0010, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    add(16'h0010, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    add(16'h0011, 8'h5A, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    add(16'h0011, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    add(16'h07FF, 8'h99, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    add(16'h07FF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    add(16'hC000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b1, 1'b0, 16'hC000, 8'h00);
    add(16'h0010, 8'hEE, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, 1'b1, 1'b0, 16'hC000, 8'h00);
    add(16'hC000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b1, 1'b0, 16'hC000, 8'h00);
    add(16'hC000, 8'h00, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 16'hC000, 8'h00);
    add(16'h8001, 8'h77, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b1, 16'h8001, 8'h77);
    add(16'h8001, 8'h77, 1'b1, 1'b1, 8'hAA, 8'h3C, 1'b1, 1'b0, 1'b1, 16'h8001, 8'h77);
    add(16'h0010, 8'h00, 1'b0, 1'b1, 8'h11, 8'hA5, 1'b1, 1'b0, 1'b1, 16'h8001, 8'h77);
    add(16'h0011, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 16'h8001, 8'h77);
    add(16'h9000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, 16'h9000, 8'h00);
    add(16'h9000, 8'h00, 1'b0, 1'b1, 8'h42, 8'h42, 1'b1, 1'b0, 1'b0, 16'h9000, 8'h00);
    add(16'h0020, 8'h66, 1'b1, 1'b0, 8'h00, 8'h42, 1'b1, 1'b0, 1'b0, 16'h9000, 8'h00);
    add(16'h0020, 8'h00, 1'b0, 1'b0, 8'h00, 8'h66, 1'b1, 1'b0, 1'b0, 16'h9000, 8'h00);
    add(16'h0800, 8'h00, 1'b0, 1'b0, 8'h00, 8'h66, 1'b0, 1'b1, 1'b0, 16'h0800, 8'h00);
    add(16'h0800, 8'h00, 1'b0, 1'b1, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0, 16'h0800, 8'h00);

    #12;
    check("rst_DI", 16'(DI), 16'h00);
    check("rst_RDY", 16'(RDY), 16'h1);
    check("rst_req", 16'(ext_req), 16'h0);
    check("rst_err", 16'(bus_err), 16'h0);
    check("rst_addr", ext_addr, 16'h0000);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      AB = vq[i].ab; DO = vq[i].dout; WE = vq[i].we;
      ext_ack = vq[i].ack; ext_rdata = vq[i].rdata; err_clr = vq[i].clr;
      step();
      check($sformatf("v%0d_DI", i), 16'(DI), 16'(vq[i].e_di));
      check($sformatf("v%0d_RDY", i), 16'(RDY), 16'(vq[i].e_rdy));
      check($sformatf("v%0d_req", i), 16'(ext_req), 16'(vq[i].e_req));
      check($sformatf("v%0d_we", i), 16'(ext_we), 16'(vq[i].e_we));
      check($sformatf("v%0d_addr", i), ext_addr, vq[i].e_addr);
      check($sformatf("v%0d_wdata", i), 16'(ext_wdata), 16'(vq[i].e_wdata));
      check($sformatf("v%0d_err", i), 16'(bus_err), 16'(vq[i].e_err));
    end
    ext_ack = 1'b0;

    // Read timeout
    run_ext(16'hF000, 8'h00, 1'b0, 0, 8'h00, 1'b0, stall);
    check("tmo_stall", 16'(stall), 16'd15);
    check("tmo_DI", 16'(DI), 16'hFF);
    check("tmo_err", 16'(bus_err), 16'h1);
    check("tmo_req", 16'(ext_req), 16'h0);

    // Stray ack while idle
    AB = 16'h0011; WE = 1'b0; ext_ack = 1'b1; ext_rdata = 8'h12;
    step();
    ext_ack = 1'b0;
    check("stray_DI", 16'(DI), 16'h5A);
    check("stray_RDY", 16'(RDY), 16'h1);
    check("stray_req", 16'(ext_req), 16'h0);
    check("stray_err", 16'(bus_err), 16'h1);

    // Clear
    err_clr = 1'b1;
    step();
    check("clr_err", 16'(bus_err), 16'h0);
    err_clr = 1'b0;
    step();
    check("clr_hold", 16'(bus_err), 16'h0);

    // Ack on the final wait edge wins over timeout
    run_ext(16'hE000, 8'h00, 1'b0, 15, 8'h5C, 1'b0, stall);
    check("late_ack_stall", 16'(stall), 16'd15);
    check("late_ack_DI", 16'(DI), 16'h5C);
    check("late_ack_err", 16'(bus_err), 16'h0);

    // Write timeout with err_clr held: set wins, DI unchanged
    run_ext(16'hA000, 8'h33, 1'b1, 0, 8'hC7, 1'b1, stall);
    check("wtmo_stall", 16'(stall), 16'd15);
    check("wtmo_DI", 16'(DI), 16'h5C);
    check("wtmo_err", 16'(bus_err), 16'h1);
    check("wtmo_we", 16'(ext_we), 16'h1);
    check("wtmo_wdata", 16'(ext_wdata), 16'h33);

    // Reset in the middle of an external access
    AB = 16'hB000; WE = 1'b0; DO = 8'h00;
    step();
    check("mid_req", 16'(ext_req), 16'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_DI", 16'(DI), 16'h00);
    check("mid_rst_RDY", 16'(RDY), 16'h1);
    check("mid_rst_req", 16'(ext_req), 16'h0);
    check("mid_rst_err", 16'(bus_err), 16'h0);
    check("mid_rst_addr", ext_addr, 16'h0000);
    #1;
    reset = 1'b1;
    AB = 16'h0020; WE = 1'b0;
    step();
    check("ram_keep_20", 16'(DI), 16'h66);
    check("ram_keep_RDY", 16'(RDY), 16'h1);
    AB = 16'h0010;
    step();
    check("ram_keep_10", 16'(DI), 16'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_6502_bus_resp.md
Name: cpu_6502_bus_resp

Overview:
Bus responder for the cpu_6502 core: the memory side of the AB/DO/WE/DI/RDY interface that the CPU drives as initiator. It serves a low address window from on-chip synchronous RAM with zero wait states. All other addresses are forwarded to a slow external port through a req/ack handshake, and the CPU is stalled via RDY until the access completes or times out. It sits between the CPU and the chip-level memory/IO pads.

Parameters:
RAM_AW, 11, internal RAM address width; the RAM window is 0x0000 to 2^RAM_AW-1 (default 2 KB).
TIMEOUT, 15, maximum number of EXT_WAIT cycles without ext_ack before the access is aborted (1..255).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
AB  input  16  address bus from the CPU.
DO  input  8  CPU write data.
WE  input  1  CPU write enable (1 = write).
DI  output  8  read data to the CPU, registered.
RDY  output  1  CPU ready, registered; 0 stalls the CPU.
ext_req  output  1  external access request, level.
ext_we  output  1  external write flag, valid while ext_req=1.
ext_addr  output  16  latched external address.
ext_wdata  output  8  latched external write data.
ext_rdata  input  8  external read data, valid with ext_ack.
ext_ack  input  1  one-cycle completion pulse from the external side.
bus_err  output  1  sticky timeout flag.
err_clr  input  1  clears bus_err.

Behaviour:
- Reset (reset=0, async): DI=0x00, RDY=1, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, bus_err=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- Reset asserted mid-access: ext_req drops immediately and the pending access is discarded.
- Address phase: on each rising edge in IDLE (RDY=1), the block samples AB/WE/DO.
- Internal hit (AB < 2^RAM_AW):
  - Read: DI <= ram[AB] at that edge, so DI is valid in the following cycle (one-cycle read latency, as the core expects).
  - Write: ram[AB] <= DO; DI holds its previous value.
  - RDY stays 1, with no stall.
- External hit (any other AB):
  - At the sampling edge: ext_addr<=AB, ext_we<=WE, ext_wdata<=DO, ext_req<=1, RDY<=0, counter<=0, state->EXT_WAIT.
- EXT_WAIT, evaluated at each edge:
  - ext_ack=1: ext_req<=0, RDY<=1, state->IDLE. If the access is a read, DI<=ext_rdata; if it is a write, DI is unchanged.
  - Otherwise, if counter==TIMEOUT-1: ext_req<=0, RDY<=1, DI<=0xFF (read) or unchanged (write), bus_err<=1, state->IDLE.
  - Otherwise: counter<=counter+1.
  - AB/WE/DO are ignored in EXT_WAIT (the CPU holds them while RDY=0).
- Latency: ext_ack on the first EXT_WAIT edge gives exactly 1 stall cycle (RDY low for one cycle). In general, RDY is low for N cycles when ack arrives on the Nth EXT_WAIT edge. A timeout gives TIMEOUT stall cycles.
- Simultaneous events:
  - ext_ack on the timeout edge: ack wins, no bus_err.
  - err_clr together with a new timeout: set wins.
  - err_clr alone: bus_err<=0 next edge.
- ext_ack while ext_req=0 (late or spurious ack): ignored, no state change.
- The first address phase after returning to IDLE is the cycle in which RDY=1 is first seen. That edge samples the CPU's next address, so back-to-back external accesses are allowed with no idle cycle.
- Counter width is 8 bits; TIMEOUT outside 1..255 is illegal.

Test Plan:
- Reset: drive reset=0 mid-run -> DI=0x00, RDY=1, ext_req=0, bus_err=0 asynchronously; RAM holds prior data.
- Internal RAM: write 0xA5 to 0x0010, then read 0x0010 -> DI=0xA5 one cycle after the read address; RDY stays 1 throughout.
- External read: AB=0xC000 read, ext_ack pulses 3 cycles after ext_req rises with ext_rdata=0x3C -> ext_addr=0xC000, ext_we=0, RDY low 3 cycles, then DI=0x3C with RDY=1.
- External write: AB=0x8001, DO=0x77, WE=1, ack on the first wait edge -> ext_we=1, ext_wdata=0x77, RDY low exactly 1 cycle, DI unchanged.
- Timeout: external read with no ack -> RDY low 15 cycles, DI=0xFF, bus_err=1. A later stray ack is ignored. err_clr -> bus_err=0. Ack on cycle 15 -> data returned, bus_err=0.
- Back-to-back: internal read, external read, internal write in consecutive address phases -> correct DI sequence, with exactly one stall window, for the external access only.
